// File: rtl/serial_add_16b_pkg.sv
// Shared types and constants for the nibble-serial adder.
// The group generate/propagate combine lives here so the top and any reuse stay consistent.
package serial_add_16b_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Fold a new (higher) slice into the running group terms: returns {g, p}.
    function automatic logic [1:0] gp_combine(input logic g_acc, input logic p_acc,
                                              input logic g_slice, input logic p_slice);
        return {g_slice | (p_slice & g_acc), p_acc & p_slice};
    endfunction

endpackage

// File: rtl/serial_add_16b_sum_4b.sv
// 4-bit carry-lookahead slice: sum, group G/P, carry out and the carry into its MSB.
module sum_4b
    import serial_add_16b_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    input  logic                i_c,
    output logic [NIBBLE_W-1:0] o_s,
    output logic                o_g,
    output logic                o_p,
    output logic                o_c,
    output logic                o_c_msb
);

    logic [NIBBLE_W-1:0] w_g;
    logic [NIBBLE_W-1:0] w_p;
    logic [NIBBLE_W-1:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    assign w_c[0] = i_c;
    assign w_c[1] = w_g[0] | (w_p[0] & i_c);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_c);

    assign o_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign o_p = &w_p;
    assign o_c = o_g | (o_p & i_c);
    assign o_c_msb = w_c[3];
    assign o_s = w_p ^ w_c;

endmodule

// File: rtl/serial_add_16b.sv
// Nibble-serial adder: one shared lookahead slice processes one 4-bit slice per cycle,
// with a valid/ready handshake on both operand and result sides.
module serial_add_16b
    import serial_add_16b_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                       c_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                       c_out,
    output logic                       ovf,
    output logic                       G,
    output logic                       P
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             r_state;
    state_t             w_next;
    logic               w_in_ready;
    logic               w_out_valid;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic               r_c_out;
    logic               r_ovf;
    logic               r_g;
    logic               r_p;
    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_s_nib;
    logic               w_g_s;
    logic               w_p_s;
    logic               w_c_s;
    logic               w_c_msb;
    logic [1:0]         w_gp;
    logic               w_last;

    assign w_a_nib = r_a[int'(r_idx)*NIBBLE_W +: NIBBLE_W];
    assign w_b_nib = r_b[int'(r_idx)*NIBBLE_W +: NIBBLE_W];
    assign w_last  = (r_idx == LAST_IDX);
    assign w_gp    = gp_combine(r_g, r_p, w_g_s, w_p_s);

    sum_4b u_slice (
        .i_a     (w_a_nib),
        .i_b     (w_b_nib),
        .i_c     (r_carry),
        .o_s     (w_s_nib),
        .o_g     (w_g_s),
        .o_p     (w_p_s),
        .o_c     (w_c_s),
        .o_c_msb (w_c_msb)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_next = RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next = DONE;
                end else begin
                    w_next = RUN;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end else begin
                    w_next = DONE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Operand capture and per-slice accumulation; result fields only move in IDLE load or RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= {W{1'b0}};
            r_b     <= {W{1'b0}};
            r_sum   <= {W{1'b0}};
            r_idx   <= {IDX_W{1'b0}};
            r_carry <= 1'b0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
            r_g     <= 1'b0;
            r_p     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= c_in;
                        r_idx   <= {IDX_W{1'b0}};
                        r_sum   <= {W{1'b0}};
                        r_g     <= 1'b0;
                        r_p     <= 1'b1;
                    end
                end
                RUN: begin
                    r_sum[int'(r_idx)*NIBBLE_W +: NIBBLE_W] <= w_s_nib;
                    r_carry <= w_c_s;
                    r_c_out <= w_c_s;
                    r_ovf   <= w_c_msb ^ w_c_s;
                    r_g     <= w_gp[1];
                    r_p     <= w_gp[0];
                    if (!w_last) begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign sum       = r_sum;
    assign c_out     = r_c_out;
    assign ovf       = r_ovf;
    assign G         = r_g;
    assign P         = r_p;

endmodule

// File: tb/tb_serial_add_16b.sv
// Scoreboard bench for serial_add_16b: the driver pushes hand-computed results on accept,
// an independent monitor compares them while out_valid is high.
module tb_serial_add_16b;
    import serial_add_16b_pkg::*;

    localparam int NIB = 4;

    typedef struct packed {
        logic [15:0] sum;
        logic        c_out;
        logic        ovf;
        logic        g;
        logic        p;
        logic [31:0] acc_cyc;
        logic [7:0]  id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        c_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        c_out;
    logic        ovf;
    logic        G;
    logic        P;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          last_hs_cyc = -100;
    int          last_acc_cyc = 0;
    logic        prev_ov = 1'b0;

    serial_add_16b #(.NIBBLES(NIB)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .ovf(ovf), .G(G), .P(P)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: compare the head of the scoreboard every cycle the result is presented.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    if (!prev_ov)
                        chk($sformatf("latency_%0d", q[0].id), cyc - int'(q[0].acc_cyc), NIB);
                    chk($sformatf("sum_%0d", q[0].id), {16'h0, sum}, {16'h0, q[0].sum});
                    chk($sformatf("c_out_%0d", q[0].id), {31'h0, c_out}, {31'h0, q[0].c_out});
                    chk($sformatf("ovf_%0d", q[0].id), {31'h0, ovf}, {31'h0, q[0].ovf});
                    chk($sformatf("G_%0d", q[0].id), {31'h0, G}, {31'h0, q[0].g});
                    chk($sformatf("P_%0d", q[0].id), {31'h0, P}, {31'h0, q[0].p});
                    if (out_ready) begin
                        void'(q.pop_front());
                        last_hs_cyc = cyc + 1;
                    end
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic send(input logic [7:0] id, input logic [15:0] va, input logic [15:0] vb,
                        input logic vc, input logic [15:0] es, input logic ec, input logic eo,
                        input logic eg, input logic ep, input bit push);
        exp_t e;
        int   n;
        a = va; b = vb; c_in = vc; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk($sformatf("accept_timeout_%0d", id), 32'd0, 32'd1);
        last_acc_cyc = cyc + 1;
        e = '{sum: es, c_out: ec, ovf: eo, g: eg, p: ep, acc_cyc: last_acc_cyc, id: id};
        if (push) q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"}, {31'h0, in_ready}, 32'd1);
        chk({tag, "_out_valid"}, {31'h0, out_valid}, 32'd0);
        chk({tag, "_sum"}, {16'h0, sum}, 32'd0);
        chk({tag, "_c_out"}, {31'h0, c_out}, 32'd0);
        chk({tag, "_ovf"}, {31'h0, ovf}, 32'd0);
        chk({tag, "_G"}, {31'h0, G}, 32'd0);
        chk({tag, "_P"}, {31'h0, P}, 32'd0);
    endtask

    initial begin
        int rel_cyc;
        int n;
        #3 chk_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        rel_cyc = cyc;
        send(8'd1, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("first_accept_after_reset", last_acc_cyc, rel_cyc + 1);
        send(8'd2, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        send(8'd3, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        send(8'd4, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        drain();

        // Hold the result with out_ready low while a second operand waits.
        out_ready = 1'b0;
        send(8'd5, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reach_done", {31'h0, out_valid}, 32'd1);
        a = 16'hABCD; b = 16'h1111; c_in = 1'b1; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("hold_in_ready", {31'h0, in_ready}, 32'd0);
            chk("hold_out_valid", {31'h0, out_valid}, 32'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(8'd6, 16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("back_to_back_accept", last_acc_cyc, last_hs_cyc + 1);
        drain();

        // Abort an operation in its second RUN cycle.
        send(8'd7, 16'h1111, 16'h1111, 1'b0, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_values("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("abort_no_result", {31'h0, out_valid}, 32'd0);
        end
        send(8'd8, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
